alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the 16-bit ALU built from 1-bit slices.
- Accepts a decoded ALU request: 4-bit funct plus two 16-bit operands.
- Translates funct into slice controls: AInvert, BInvert, bit-0 carry-in CIN, and the 3-bit Op that drives the slice result mux.
- Buffers requests in a 2-entry FIFO with valid/ready handshakes on both sides, so the execute stage can stall.

Parameters:
- WIDTH, 16, operand width in bits.
- DEPTH, 2, buffer entries; fixed at 2, so pointers are 1 bit.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- InValid  input  1  request present
- InReady  output  1  stage can accept a request; equals count<2
- InFunct  input  4  ALU function code
- InA  input  WIDTH  operand A
- InB  input  WIDTH  operand B
- InUseImm  input  1  select immediate for B; used only with the macro
- InImm  input  6  signed immediate; used only with the macro
- OutValid  output  1  head entry valid
- OutReady  input  1  ALU/EX consumes the head entry
- OutA  output  WIDTH  operand A to the slices
- OutB  output  WIDTH  operand B to the slices
- OutAInvert  output  1  slice AInvert
- OutBInvert  output  1  slice BInvert
- OutCIN  output  1  carry-in of slice 0
- OutOp  output  3  slice Op select
- OutIllegal  output  1  head funct was undefined

Behaviour:
- Slice Op encoding: 000 AND, 001 SUB (slice forces B inversion), 010 OR, 011 XOR, 100 ADD, 101 SLT (Less).
- Funct decode, given as funct -> {AInvert, BInvert, CIN, Op}:
  - 0000 AND -> {0,0,0,000}
  - 0001 OR -> {0,0,0,010}
  - 0010 XOR -> {0,0,0,011}
  - 0011 ADD -> {0,0,0,100}
  - 0100 SUB -> {0,1,1,001}
  - 0101 SLT -> {0,1,1,101}
  - 0110 NOR -> {1,1,0,000}
  - 0111 NAND -> {1,1,0,010}
- Funct 1000-1111: controls all 0, Op=000, OutIllegal=1; operands still pass through and the entry is still queued.
- Decode is combinational at the input. The decoded controls and operands are stored together in the entry.
- Push occurs when InValid && InReady. Pop occurs when OutValid && OutReady.
- Latency: push into an empty buffer shows OutValid=1 with that entry on the following cycle. No same-cycle bypass.
- Count is 0..2:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; allowed when count is 1 (full, count 2, blocks push via InReady=0).
- Read/write pointers are 1 bit and wrap 1->0.
- Out* show the head entry. While OutValid=1 && OutReady=0, all Out* hold stable.
- When empty (OutValid=0), Out* data outputs are driven 0.
- InValid while InReady=0: ignored, with no side effects.
- Reset, including mid-operation: count=0, pointers=0, OutValid=0, all Out* data=0, InReady=1 from the first cycle after reset. Buffered entries are discarded.

Optional Feature:
- Macro: ALU_ISSUE_IMM_EN.
- Defined: when InUseImm=1 at push, the stored B is InImm sign-extended to WIDTH and InB is ignored. Decode is unchanged.
- Undefined: InUseImm and InImm are ignored, and stored B is always InB.

Decomposition:
- Package alu_issue_pkg holds:
  - FUNCT_* constants (4-bit)
  - OP_AND/OP_SUB/OP_OR/OP_XOR/OP_ADD/OP_SLT constants (3-bit)
  - the stored-entry control bundle: AInvert, BInvert, CIN, Op, Illegal
- Sub-module alu_ctrl_decode: combinational funct -> control bundle. It is reused by the bench as the reference model.

Test Plan:
- Decode sweep: push funct 0000..0111 with A=16'h00F0, B=16'h0F0F and OutReady=1. Each output entry appears one cycle after push with the tabled controls, e.g. SUB -> {0,1,1,001} and NOR -> {1,1,0,000}, with OutIllegal=0.
- Illegal: push funct 1010, A=16'h1234. Output shows Op=000, all controls 0, OutIllegal=1, OutA=16'h1234.
- Backpressure: OutReady=0, push 3 requests on consecutive cycles. The first two are accepted, InReady drops to 0 after the second, the third is held off, and Out* stay frozen on entry 1. Raising OutReady drains entries in order 1, 2, then the third is accepted.
- Simultaneous push/pop at count 1 for 10 cycles: count stays 1, pointers wrap, and the order is preserved.
- Reset with 2 entries buffered: next cycle OutValid=0, InReady=1, Out* = 0.
- With ALU_ISSUE_IMM_EN defined: InUseImm=1, InImm=6'b111110, InB=16'hAAAA -> OutB=16'hFFFE. With the macro undefined, the same stimulus gives OutB=16'hAAAA.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and encodings for the ALU issue stage and its funct decoder.
package alu_issue_pkg;

  localparam logic [3:0] FUNCT_AND  = 4'b0000;
  localparam logic [3:0] FUNCT_OR   = 4'b0001;
  localparam logic [3:0] FUNCT_XOR  = 4'b0010;
  localparam logic [3:0] FUNCT_ADD  = 4'b0011;
  localparam logic [3:0] FUNCT_SUB  = 4'b0100;
  localparam logic [3:0] FUNCT_SLT  = 4'b0101;
  localparam logic [3:0] FUNCT_NOR  = 4'b0110;
  localparam logic [3:0] FUNCT_NAND = 4'b0111;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  // Slice control bundle stored alongside the operands in each buffer entry.
  typedef struct packed {
    logic       ainvert;
    logic       binvert;
    logic       cin;
    logic [2:0] op;
    logic       illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational translation of a 4-bit ALU funct into 1-bit-slice controls.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [3:0] funct,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    // NOTE: default every field first so no path through the case infers a latch.
    ctrl = '0;
    unique case (funct)
      FUNCT_AND:  ctrl.op = OP_AND;
      FUNCT_OR:   ctrl.op = OP_OR;
      FUNCT_XOR:  ctrl.op = OP_XOR;
      FUNCT_ADD:  ctrl.op = OP_ADD;
      FUNCT_SUB: begin
        ctrl.binvert = 1'b1;
        ctrl.cin     = 1'b1;
        ctrl.op      = OP_SUB;
      end
      FUNCT_SLT: begin
        ctrl.binvert = 1'b1;
        ctrl.cin     = 1'b1;
        ctrl.op      = OP_SLT;
      end
      FUNCT_NOR: begin
        ctrl.ainvert = 1'b1;
        ctrl.binvert = 1'b1;
        ctrl.op      = OP_AND;
      end
      FUNCT_NAND: begin
        ctrl.ainvert = 1'b1;
        ctrl.binvert = 1'b1;
        ctrl.op      = OP_OR;
      end
      default:    ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered 2-entry issue buffer feeding the 16-bit slice ALU with decoded controls.
// Optional macro ALU_ISSUE_IMM_EN: in_use_imm selects the sign-extended 6-bit in_imm as operand B.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_imm,
  input  logic [5:0]       in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_ainvert,
  output logic             out_binvert,
  output logic             out_cin,
  output logic [2:0]       out_op,
  output logic             out_illegal
);

  alu_ctrl_t        in_ctrl;
  logic [WIDTH-1:0] b_sel;

  logic [WIDTH-1:0] mem_a    [DEPTH];
  logic [WIDTH-1:0] mem_b    [DEPTH];
  alu_ctrl_t        mem_ctrl [DEPTH];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  alu_ctrl_t  head_ctrl;

  alu_ctrl_decode u_decode (
    .funct (in_funct),
    .ctrl  (in_ctrl)
  );

`ifdef ALU_ISSUE_IMM_EN
  assign b_sel = in_use_imm ? {{(WIDTH-6){in_imm[5]}}, in_imm} : in_b;
`else
  logic unused_imm;
  assign unused_imm = ^{in_use_imm, in_imm};
  assign b_sel      = in_b;
`endif

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset; empty-state outputs are masked by out_valid instead.
  // With count==1 the write slot differs from the head, so a stalled head never changes.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]    <= in_a;
      mem_b[wr_ptr]    <= b_sel;
      mem_ctrl[wr_ptr] <= in_ctrl;
    end
  end

  always_comb begin
    head_ctrl = '0;
    out_a     = '0;
    out_b     = '0;
    if (out_valid) begin
      head_ctrl = mem_ctrl[rd_ptr];
      out_a     = mem_a[rd_ptr];
      out_b     = mem_b[rd_ptr];
    end
  end

  assign out_ainvert = head_ctrl.ainvert;
  assign out_binvert = head_ctrl.binvert;
  assign out_cin     = head_ctrl.cin;
  assign out_op      = head_ctrl.op;
  assign out_illegal = head_ctrl.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected controls are hand-tabled.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_funct;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_use_imm;
  logic [5:0]  in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        out_ainvert;
  logic        out_binvert;
  logic        out_cin;
  logic [2:0]  out_op;
  logic        out_illegal;

  logic [3:0]  ref_funct;
  alu_ctrl_t   ref_ctrl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_use_imm  (in_use_imm),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_ainvert (out_ainvert),
    .out_binvert (out_binvert),
    .out_cin     (out_cin),
    .out_op      (out_op),
    .out_illegal (out_illegal)
  );

  alu_ctrl_decode u_ref (
    .funct (ref_funct),
    .ctrl  (ref_ctrl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand table {ainvert, binvert, cin, op, illegal}.
  function automatic logic [6:0] exp_ctrl(input logic [3:0] f);
    case (f)
      4'd0:    return 7'b000_000_0;
      4'd1:    return 7'b000_010_0;
      4'd2:    return 7'b000_011_0;
      4'd3:    return 7'b000_100_0;
      4'd4:    return 7'b011_001_0;
      4'd5:    return 7'b011_101_0;
      4'd6:    return 7'b110_000_0;
      4'd7:    return 7'b110_010_0;
      default: return 7'b000_000_1;
    endcase
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {out_ainvert, out_binvert, out_cin, out_op, out_illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_funct = f;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_a"}, 32'(out_a), 32'd0);
    check({tag, "_b"}, 32'(out_b), 32'd0);
    check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'd0);
  endtask

  task automatic check_head(input string tag, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(exp_ctrl(f)));
    check({tag, "_a"}, 32'(out_a), 32'(a));
    check({tag, "_b"}, 32'(out_b), 32'(b));
  endtask

  initial begin
    reset      = 1'b1;
    out_ready  = 1'b0;
    in_use_imm = 1'b0;
    in_imm     = 6'd0;
    ref_funct  = 4'd0;
    drive(1'b0, 4'd0, 16'h0, 16'h0);

    // Reference decoder against the hand table, all 16 codes.
    for (int f = 0; f < 16; f++) begin
      ref_funct = 4'(f);
      #1;
      check($sformatf("refdec_%0d", f), 32'(ref_ctrl), 32'(exp_ctrl(4'(f))));
    end

    tick();
    tick();
    reset = 1'b0;
    check_empty("reset");

    // Decode sweep, streaming at one entry per cycle.
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 4'(f), 16'h00F0, 16'h0F0F);
      tick();
      check_head($sformatf("sweep_%0d", f), 4'(f), 16'h00F0, 16'h0F0F);
    end
    drive(1'b0, 4'd0, 16'h0, 16'h0);
    tick();
    check_empty("sweep_drain");

    // Illegal funct still queues with operands.
    drive(1'b1, 4'b1010, 16'h1234, 16'h5678);
    tick();
    check_head("illegal", 4'b1010, 16'h1234, 16'h5678);
    drive(1'b0, 4'd0, 16'h0, 16'h0);
    tick();
    check_empty("illegal_drain");

    // Backpressure: two accepted, third held off until space frees.
    out_ready = 1'b0;
    drive(1'b1, FUNCT_ADD, 16'h1111, 16'h2222);
    tick();
    check_head("bp_e1", FUNCT_ADD, 16'h1111, 16'h2222);
    check("bp_ready1", 32'(in_ready), 32'd1);
    drive(1'b1, FUNCT_SUB, 16'h3333, 16'h4444);
    tick();
    check_head("bp_full", FUNCT_ADD, 16'h1111, 16'h2222);
    check("bp_ready2", 32'(in_ready), 32'd0);
    drive(1'b1, FUNCT_OR, 16'h5555, 16'h6666);
    tick();
    check_head("bp_hold", FUNCT_ADD, 16'h1111, 16'h2222);
    check("bp_ready3", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check_head("bp_e2", FUNCT_SUB, 16'h3333, 16'h4444);
    check("bp_ready4", 32'(in_ready), 32'd1);
    tick();
    check_head("bp_e3", FUNCT_OR, 16'h5555, 16'h6666);
    drive(1'b0, 4'd0, 16'h0, 16'h0);
    tick();
    check_empty("bp_drain");

    // Simultaneous push/pop at count 1 across pointer wraps.
    drive(1'b1, 4'd0, 16'h0100, 16'h0200);
    tick();
    check_head("pp_0", 4'd0, 16'h0100, 16'h0200);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 4'(k % 8), 16'h0100 + 16'(k), 16'h0200 + 16'(k));
      tick();
      check_head($sformatf("pp_%0d", k), 4'(k % 8), 16'h0100 + 16'(k), 16'h0200 + 16'(k));
      check($sformatf("pp_ready_%0d", k), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 4'd0, 16'h0, 16'h0);
    tick();
    check_empty("pp_drain");

    // Reset while full discards both entries.
    out_ready = 1'b0;
    drive(1'b1, FUNCT_XOR, 16'hBEEF, 16'hCAFE);
    tick();
    drive(1'b1, FUNCT_NOR, 16'hDEAD, 16'hF00D);
    tick();
    check("mid_full", 32'(in_ready), 32'd0);
    drive(1'b0, 4'd0, 16'h0, 16'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_empty("mid_reset");
    out_ready = 1'b1;
    tick();
    check_empty("mid_reset_after");

    // Immediate select for operand B.
    in_use_imm = 1'b1;
    in_imm     = 6'b111110;
    drive(1'b1, FUNCT_ADD, 16'h0001, 16'hAAAA);
    tick();
`ifdef ALU_ISSUE_IMM_EN
    check_head("imm", FUNCT_ADD, 16'h0001, 16'hFFFE);
`else
    check_head("imm", FUNCT_ADD, 16'h0001, 16'hAAAA);
`endif
    in_use_imm = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 16'h0);
    tick();
    check_empty("imm_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
